// File: rtl/adam_periph_gpio_filter_pkg.sv
// Shared typedefs and defaults for the ADAM GPIO input filter.
package adam_periph_gpio_filter_pkg;

  localparam int DEFAULT_GPIO_WIDTH = 16;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef logic [DEFAULT_GPIO_WIDTH-1:0] GPIO_T;
  typedef logic [DEFAULT_CNT_WIDTH-1:0]  CNT_T;

  typedef enum logic {
    PAUSE_RUN  = 1'b0,
    PAUSE_HELD = 1'b1
  } pause_state_e;

endpackage

// File: rtl/adam_periph_gpio_filter_pin.sv
// One pin of the GPIO input filter: 2-flop synchroniser, stability counter,
// filtered data bit and (with ADAM_GPIO_FILTER_EDGE_EN) edge pulse registers.
module adam_periph_gpio_filter_pin
  import adam_periph_gpio_filter_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin,
  input  logic                 filt_en,
  input  logic                 tick,
  input  logic                 paused,
  input  logic [CNT_WIDTH-1:0] thresh,
  output logic                 idr,
  output logic                 rise,
  output logic                 fall
);

  logic                 sync1_reg;
  logic                 sync2_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 idr_reg;
  logic                 idr_next;

  always_comb begin
    idr_next = idr_reg;
    cnt_next = cnt_reg;
    if (!paused) begin
      if (!filt_en) begin
        idr_next = sync2_reg;
        cnt_next = '0;
      end else if (sync2_reg == idr_reg) begin
        cnt_next = '0;
      end else if (tick) begin
        // Accept test precedes the increment, so the counter cannot overflow.
        if (cnt_reg >= thresh) begin
          idr_next = sync2_reg;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      idr_reg   <= 1'b0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      idr_reg   <= idr_next;
    end
  end

  assign idr = idr_reg;

`ifdef ADAM_GPIO_FILTER_EDGE_EN
  logic rise_reg;
  logic fall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= idr_next & ~idr_reg;
      fall_reg <= ~idr_next & idr_reg;
    end
  end

  // A pulse registered on the edge that entered pause is suppressed too.
  assign rise = rise_reg & ~paused;
  assign fall = fall_reg & ~paused;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/adam_periph_gpio_filter.sv
// ADAM GPIO input filter: shared prescaler and pause handshake around per-pin
// debounce slices. Edge outputs exist only when ADAM_GPIO_FILTER_EDGE_EN is defined.
module adam_periph_gpio_filter
  import adam_periph_gpio_filter_pkg::*;
#(
  parameter int GPIO_WIDTH = DEFAULT_GPIO_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic [GPIO_WIDTH-1:0] pin_i,
  input  logic [GPIO_WIDTH-1:0] filt_en,
  input  logic [CNT_WIDTH-1:0]  presc,
  input  logic [CNT_WIDTH-1:0]  thresh,
  output logic [GPIO_WIDTH-1:0] idr,
  output logic [GPIO_WIDTH-1:0] rise,
  output logic [GPIO_WIDTH-1:0] fall
);

  pause_state_e         pause_state_reg;
  logic [CNT_WIDTH-1:0] pc_reg;
  logic                 paused;
  logic                 tick;

  assign paused    = (pause_state_reg == PAUSE_HELD);
  assign pause_ack = paused;
  // >= rather than == so that lowering presc below pc wraps on the next cycle.
  assign tick      = (pc_reg >= presc) && !paused;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_state_reg <= PAUSE_RUN;
      pc_reg          <= '0;
    end else begin
      pause_state_reg <= pause_req ? PAUSE_HELD : PAUSE_RUN;
      if (!paused) begin
        pc_reg <= tick ? '0 : pc_reg + CNT_WIDTH'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pin
      adam_periph_gpio_filter_pin #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_pin (
        .clk    (clk),
        .rst    (rst),
        .pin    (pin_i[gi]),
        .filt_en(filt_en[gi]),
        .tick   (tick),
        .paused (paused),
        .thresh (thresh),
        .idr    (idr[gi]),
        .rise   (rise[gi]),
        .fall   (fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_adam_periph_gpio_filter.sv
// Self-checking bench for adam_periph_gpio_filter: per-cycle reference model
// plus directed literal checks and a randomized soak.
module tb_adam_periph_gpio_filter;

  localparam int W = 16;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pause_req = 1'b0;
  logic         pause_ack;
  logic [W-1:0] pin_i = '1;
  logic [W-1:0] filt_en = '0;
  logic [C-1:0] presc = '0;
  logic [C-1:0] thresh = '0;
  logic [W-1:0] idr;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int n_checks = 0;
  int n_errors = 0;

  adam_periph_gpio_filter #(
    .GPIO_WIDTH(W),
    .CNT_WIDTH (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pause_req(pause_req),
    .pause_ack(pause_ack),
    .pin_i    (pin_i),
    .filt_en  (filt_en),
    .presc    (presc),
    .thresh   (thresh),
    .idr      (idr),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 clk = ~clk;

  // Reference model state: what the spec's rules say the block holds.
  logic [W-1:0] m_s1, m_s2, m_idr, m_rise, m_fall;
  int           m_cnt [W];
  int           m_pc;
  logic         m_ack;

`ifdef ADAM_GPIO_FILTER_EDGE_EN
  localparam bit EDGES = 1'b1;
`else
  localparam bit EDGES = 1'b0;
`endif

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] old_idr;
    bit           tick;
    old_idr = m_idr;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_idr = '0; m_pc = 0; m_ack = 1'b0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_rise = '0; m_fall = '0;
    end else begin
      tick = (m_pc >= int'(presc)) && !m_ack;
      if (!m_ack) begin
        m_pc = tick ? 0 : m_pc + 1;
        for (int i = 0; i < W; i++) begin
          if (!filt_en[i]) begin
            m_idr[i] = m_s2[i];
            m_cnt[i] = 0;
          end else if (m_s2[i] == m_idr[i]) begin
            m_cnt[i] = 0;
          end else if (tick) begin
            if (m_cnt[i] >= int'(thresh)) begin
              m_idr[i] = m_s2[i];
              m_cnt[i] = 0;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
      end
      m_s2  = m_s1;
      m_s1  = pin_i;
      m_ack = pause_req;
      m_rise = EDGES ? ((m_idr & ~old_idr) & {W{~m_ack}}) : '0;
      m_fall = EDGES ? ((~m_idr & old_idr) & {W{~m_ack}}) : '0;
    end
  endtask

  // Single compare process: advance model on every edge, compare 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_idr", idr, m_idr);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_ack", {{(W-1){1'b0}}, pause_ack}, {{(W-1){1'b0}}, m_ack});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  n;
  bit  seen;
  logic [W-1:0] mask;

  initial begin
    // Reset with pins high: everything must read 0.
    cycles(4);
    check("rst_idr", idr, 16'h0000);
    check("rst_rise", rise, 16'h0000);
    check("rst_fall", fall, 16'h0000);
    check("rst_ack", {15'd0, pause_ack}, 16'h0000);
    rst = 1'b0;
    cycles(3);
    pin_i = '0;
    cycles(6);

    // Bypass: idr follows two edges after the change; rise pulses one cycle.
    pin_i = 16'h00A5;
    @(posedge clk); @(posedge clk); #1;
    check("byp_idr_k1", idr, 16'h0000);
    @(posedge clk); #1;
    check("byp_idr_k2", idr, 16'h00A5);
    if (EDGES) check("byp_rise_k2", rise, 16'h00A5);
    @(posedge clk); #1;
    check("byp_rise_k3", rise, 16'h0000);

    // Debounce accept on pin 0, thresh 4, presc 0.
    @(negedge clk);
    filt_en = 16'h0001; presc = 0; thresh = 4; pin_i = 16'h0000;
    cycles(14);
    pin_i = 16'h0001;
    repeat (6) @(posedge clk);
    #1 check("deb_idr_k5", idr, 16'h0000);
    repeat (2) @(posedge clk);
    #1 check("deb_idr_k7", idr, 16'h0001);

    // Glitch reject: 12 high cycles cannot reach 5 ticks of 4 cycles.
    @(negedge clk);
    presc = 3; pin_i = 16'h0000;
    cycles(40);
    seen = 1'b0;
    pin_i = 16'h0001;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (i == 11) pin_i = 16'h0000;
      seen = seen | idr[0] | fall[0];
    end
    check("glitch_reject", {15'd0, seen}, 16'h0000);

    // Prescaler: presc 9, thresh 2 -> 3 ticks of 10 cycles.
    presc = 9; thresh = 2;
    cycles(60);
    pin_i = 16'h0001;
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++; #1;
      if (idr[0]) break;
    end
    if (!idr[0]) n = 999;
    check("presc_latency_in_range", {15'd0, (n >= 22 && n <= 42)}, 16'h0001);

    // Pause mid-count: 5 ticks, 20 paused cycles, then 6 more ticks.
    @(negedge clk);
    presc = 0; thresh = 10; pin_i = 16'h0000;
    cycles(30);
    pin_i = 16'h0001;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pause_ack_before", {15'd0, pause_ack}, 16'h0000);
    pause_req = 1'b1;
    @(posedge clk); #1;
    check("pause_ack_after", {15'd0, pause_ack}, 16'h0001);
    cycles(20);
    check("pause_idr_frozen", idr, 16'h0000);
    pause_req = 1'b0;
    @(posedge clk); #1;
    check("pause_ack_release", {15'd0, pause_ack}, 16'h0000);
    repeat (5) @(posedge clk);
    #1 check("pause_idr_r5", idr, 16'h0000);
    @(posedge clk);
    #1 check("pause_idr_r6", idr, 16'h0001);

    // Randomized soak with bouncing pins, config changes, pauses and a reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      mask  = W'($urandom & $urandom & $urandom & $urandom);
      pin_i = pin_i ^ mask;
      if (cyc % 200 == 0) begin
        filt_en = W'($urandom);
        presc   = C'($urandom_range(0, 3));
        thresh  = C'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
      rst = (cyc >= 1500 && cyc < 1502);
    end
    pause_req = 1'b0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
